// File: rtl/display_sequencer.sv
// Panel power sequencer and frame-synchronous double-buffer swap scheduler.
// Powers the panel up as reset pulse, then wake delay, then timing start,
// then first frame, then backlight delay. Video and backlight are gated on
// frame boundaries. A renderer swap request is applied only at the end of
// the active frame.
module display_sequencer #(
    parameter int unsigned RESET_CYCLES    = 300,
    parameter int unsigned WAKE_CYCLES     = 3600000,
    parameter int unsigned BL_DELAY_FRAMES = 2
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       swap_req,
    output logic       panel_rst_n,
    output logic       timing_rst_n,
    output logic       video_en,
    output logic       bl_en,
    output logic       front_buf,
    output logic       swap_ack,
    output logic [7:0] frame_count
);

    localparam logic [9:0]  LAST_X     = 10'd479;
    localparam logic [9:0]  LAST_Y     = 10'd799;
    localparam logic [23:0] RESET_LOAD = 24'(RESET_CYCLES);
    localparam logic [23:0] WAKE_LOAD  = 24'(WAKE_CYCLES);
    localparam logic [23:0] BL_LOAD    = 24'(BL_DELAY_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_ASSERT,
        ST_WAKE_WAIT,
        ST_FIRST_FRAME,
        ST_BL_WAIT,
        ST_RUN,
        ST_SHUTDOWN
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        panel_rst_n_q, panel_rst_n_d;
    logic        timing_rst_n_q, timing_rst_n_d;
    logic        video_en_q, video_en_d;
    logic        bl_en_q, bl_en_d;
    logic        front_buf_q, front_buf_d;
    logic        swap_ack_q, swap_ack_d;
    logic [7:0]  frame_count_q, frame_count_d;

    logic        frame_end;
    logic        swap_window;

    // A generator held in reset reports 0,0, but gating on our own
    // timing_rst_n keeps a stray coordinate from counting as a frame end.
    assign frame_end   = timing_rst_n_q && (pixel_x == LAST_X) && (pixel_y == LAST_Y);
    assign swap_window = (state_q == ST_BL_WAIT) || (state_q == ST_RUN);

    // Next-state, delay counter, and next value of every registered output.
    always_comb begin
        // NOTE: every _d gets a default first; a path that left one unassigned would infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        panel_rst_n_d  = panel_rst_n_q;
        timing_rst_n_d = timing_rst_n_q;
        video_en_d     = video_en_q;
        bl_en_d        = bl_en_q;
        front_buf_d    = front_buf_q;
        swap_ack_d     = 1'b0;
        frame_count_d  = frame_end ? frame_count_q + 8'd1 : frame_count_q;

        // Swaps happen only at end of frame once video is live and not
        // shutting down; a request raised elsewhere stays pending.
        if (swap_window && frame_end && swap_req) begin
            front_buf_d = ~front_buf_q;
            swap_ack_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                panel_rst_n_d  = 1'b0;
                timing_rst_n_d = 1'b0;
                video_en_d     = 1'b0;
                bl_en_d        = 1'b0;
                if (enable) begin
                    state_d = ST_RESET_ASSERT;
                    cnt_d   = RESET_LOAD;
                end
            end

            ST_RESET_ASSERT: begin
                panel_rst_n_d = 1'b0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 24'd1) begin
                    state_d       = ST_WAKE_WAIT;
                    cnt_d         = WAKE_LOAD;
                    panel_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end

            ST_WAKE_WAIT: begin
                if (!enable) begin
                    state_d       = ST_IDLE;
                    panel_rst_n_d = 1'b0;
                end else if (cnt_q == 24'd1) begin
                    state_d        = ST_FIRST_FRAME;
                    timing_rst_n_d = 1'b1;
                    frame_count_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end

            ST_FIRST_FRAME: begin
                if (!enable) begin
                    state_d = ST_SHUTDOWN;
                    bl_en_d = 1'b0;
                end else if (frame_end) begin
                    state_d    = ST_BL_WAIT;
                    video_en_d = 1'b1;
                    cnt_d      = BL_LOAD;
                end
            end

            ST_BL_WAIT: begin
                if (!enable) begin
                    state_d = ST_SHUTDOWN;
                    bl_en_d = 1'b0;
                end else if (frame_end) begin
                    if (cnt_q == 24'd1) begin
                        state_d = ST_RUN;
                        bl_en_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 24'd1;
                    end
                end
            end

            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_SHUTDOWN;
                    bl_en_d = 1'b0;
                end
            end

            // Runs to completion even if enable returns; restart goes via IDLE.
            ST_SHUTDOWN: begin
                if (frame_end) begin
                    state_d        = ST_IDLE;
                    video_en_d     = 1'b0;
                    timing_rst_n_d = 1'b0;
                    panel_rst_n_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers; rst_n clears everything including buffer index and frame count.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 24'd0;
            panel_rst_n_q  <= 1'b0;
            timing_rst_n_q <= 1'b0;
            video_en_q     <= 1'b0;
            bl_en_q        <= 1'b0;
            front_buf_q    <= 1'b0;
            swap_ack_q     <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            panel_rst_n_q  <= panel_rst_n_d;
            timing_rst_n_q <= timing_rst_n_d;
            video_en_q     <= video_en_d;
            bl_en_q        <= bl_en_d;
            front_buf_q    <= front_buf_d;
            swap_ack_q     <= swap_ack_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign panel_rst_n  = panel_rst_n_q;
    assign timing_rst_n = timing_rst_n_q;
    assign video_en     = video_en_q;
    assign bl_en        = bl_en_q;
    assign front_buf    = front_buf_q;
    assign swap_ack     = swap_ack_q;
    assign frame_count  = frame_count_q;

    // Structural invariants of the power sequence and swap handshake.
    a_bl_needs_video: assert property (@(posedge clk_pixel) disable iff (!rst_n)
        bl_en |-> (video_en && timing_rst_n && panel_rst_n));
    a_video_needs_timing: assert property (@(posedge clk_pixel) disable iff (!rst_n)
        video_en |-> timing_rst_n);
    a_timing_needs_panel: assert property (@(posedge clk_pixel) disable iff (!rst_n)
        timing_rst_n |-> panel_rst_n);
    a_ack_with_toggle: assert property (@(posedge clk_pixel) disable iff (!rst_n)
        swap_ack |-> (front_buf != $past(front_buf)));

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: directed power-up, swap,
// shutdown, abort and async-reset steps, plus random lifecycles, all checked
// every cycle against a phase-countdown reference model.
module tb_display_sequencer;

    localparam int R = 4;
    localparam int W = 10;
    localparam int B = 2;

    logic       clk_pixel = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b0;
    logic [9:0] pixel_x   = 10'd0;
    logic [9:0] pixel_y   = 10'd0;
    logic       swap_req  = 1'b0;
    logic       panel_rst_n, timing_rst_n, video_en, bl_en, front_buf, swap_ack;
    logic [7:0] frame_count;

    display_sequencer #(
        .RESET_CYCLES   (R),
        .WAKE_CYCLES    (W),
        .BL_DELAY_FRAMES(B)
    ) dut (
        .clk_pixel   (clk_pixel),
        .rst_n       (rst_n),
        .enable      (enable),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .swap_req    (swap_req),
        .panel_rst_n (panel_rst_n),
        .timing_rst_n(timing_rst_n),
        .video_en    (video_en),
        .bl_en       (bl_en),
        .front_buf   (front_buf),
        .swap_ack    (swap_ack),
        .frame_count (frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: panel life as a powered flag plus remaining-time counters.
    bit         m_powered, m_shutting;
    int         m_rst_left, m_wake_left, m_bl_left;
    logic       m_panel, m_timing, m_video, m_bl, m_front, m_ack;
    logic [7:0] m_count;

    int   panel_rise_cyc, timing_rise_cyc, en_edge, guard;
    logic prev_panel, prev_timing;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_powered   = 1'b0;
        m_shutting  = 1'b0;
        m_rst_left  = 0;
        m_wake_left = 0;
        m_bl_left   = 0;
        m_panel     = 1'b0;
        m_timing    = 1'b0;
        m_video     = 1'b0;
        m_bl        = 1'b0;
        m_front     = 1'b0;
        m_ack       = 1'b0;
        m_count     = 8'd0;
    endtask

    task automatic model_step();
        bit fe;
        bit swap_ok;
        fe      = m_timing && (pixel_x == 10'd479) && (pixel_y == 10'd799);
        swap_ok = m_video && !m_shutting;
        m_ack   = 1'b0;
        if (fe) m_count = m_count + 8'd1;
        if (fe && swap_ok && swap_req) begin
            m_front = ~m_front;
            m_ack   = 1'b1;
        end
        if (!m_powered) begin
            m_panel = 0; m_timing = 0; m_video = 0; m_bl = 0;
            if (enable) begin
                m_powered  = 1'b1;
                m_rst_left = R;
            end
        end else if (m_rst_left > 0) begin
            if (!enable) m_powered = 1'b0;
            else begin
                m_rst_left--;
                if (m_rst_left == 0) begin
                    m_panel     = 1'b1;
                    m_wake_left = W;
                end
            end
        end else if (m_wake_left > 0) begin
            if (!enable) begin
                m_powered = 1'b0;
                m_panel   = 1'b0;
            end else begin
                m_wake_left--;
                if (m_wake_left == 0) begin
                    m_timing = 1'b1;
                    m_count  = 8'd0;
                end
            end
        end else if (m_shutting) begin
            if (fe) begin
                m_video = 0; m_timing = 0; m_panel = 0;
                m_powered = 1'b0; m_shutting = 1'b0;
            end
        end else if (!enable) begin
            m_bl       = 1'b0;
            m_shutting = 1'b1;
        end else if (fe) begin
            if (!m_video) begin
                m_video   = 1'b1;
                m_bl_left = B;
            end else if (!m_bl) begin
                m_bl_left--;
                if (m_bl_left == 0) m_bl = 1'b1;
            end
        end
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare.
    task automatic tick();
        @(posedge clk_pixel);
        cyc++;
        if (!rst_n) model_reset();
        else model_step();
        #1;
        chk1("panel_rst_n", panel_rst_n, m_panel);
        chk1("timing_rst_n", timing_rst_n, m_timing);
        chk1("video_en", video_en, m_video);
        chk1("bl_en", bl_en, m_bl);
        chk1("front_buf", front_buf, m_front);
        chk1("swap_ack", swap_ack, m_ack);
        chk8("frame_count", frame_count, m_count);
        if (!prev_panel && panel_rst_n === 1'b1) panel_rise_cyc = cyc;
        if (!prev_timing && timing_rst_n === 1'b1) timing_rise_cyc = cyc;
        prev_panel  = panel_rst_n;
        prev_timing = timing_rst_n;
    endtask

    task automatic set_mid_pix();
        pixel_x = 10'($urandom_range(0, 479));
        pixel_y = 10'($urandom_range(0, 799));
        if (pixel_x == 10'd479 && pixel_y == 10'd799) pixel_y = 10'd798;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            set_mid_pix();
            tick();
        end
    endtask

    task automatic fe_tick();
        pixel_x = 10'd479;
        pixel_y = 10'd799;
        tick();
    endtask

    task automatic rand_pix(input int fe_odds);
        if ($urandom_range(0, fe_odds - 1) == 0) begin
            pixel_x = 10'd479;
            pixel_y = 10'd799;
        end else begin
            set_mid_pix();
        end
    endtask

    initial begin
        model_reset();
        prev_panel      = 1'b0;
        prev_timing     = 1'b0;
        panel_rise_cyc  = -1;
        timing_rise_cyc = -1;

        // Reset state
        tick();
        tick();
        chk1("rst_panel", panel_rst_n, 1'b0);
        chk1("rst_bl", bl_en, 1'b0);
        chk8("rst_count", frame_count, 8'd0);
        rst_n = 1'b1;
        run(3);

        // Power-up; frame-end coordinates during wake must not count
        enable  = 1'b1;
        en_edge = cyc + 1;
        run(R);
        fe_tick();
        fe_tick();
        run(W);
        chki("reset_pulse_len", panel_rise_cyc - en_edge, R);
        chki("wake_len", timing_rise_cyc - panel_rise_cyc, W);
        chk8("count_at_timing_start", frame_count, 8'd0);

        // Early swap request in FIRST_FRAME: no ack until the BL_WAIT frame end
        swap_req = 1'b1;
        run(5);
        fe_tick();
        chk1("ff_no_ack", swap_ack, 1'b0);
        chk1("video_after_fe1", video_en, 1'b1);
        run(7);
        fe_tick();
        chk1("early_swap_ack", swap_ack, 1'b1);
        chk1("early_swap_front", front_buf, 1'b1);
        swap_req = 1'b0;
        run(1);
        chk1("ack_one_cycle", swap_ack, 1'b0);
        run(4);
        fe_tick();
        chk1("bl_after_fe3", bl_en, 1'b1);
        chk8("count_at_bl", frame_count, 8'd3);

        // RUN: mid-frame request, then a request held across two frame ends
        run(20);
        swap_req = 1'b1;
        run(10);
        fe_tick();
        chk1("run_swap_ack", swap_ack, 1'b1);
        chk1("run_swap_front", front_buf, 1'b0);
        run(30);
        fe_tick();
        chk1("held_swap_front", front_buf, 1'b1);
        swap_req = 1'b0;
        run(30);
        fe_tick();
        chk1("dropped_no_ack", swap_ack, 1'b0);

        // Near-miss coordinates are not frame ends
        pixel_x = 10'd479; pixel_y = 10'd798; tick();
        pixel_x = 10'd478; pixel_y = 10'd799; tick();
        chk8("near_miss_count", frame_count, 8'd6);

        // Random traffic in RUN
        for (int i = 0; i < 300; i++) begin
            rand_pix(8);
            swap_req = ($urandom_range(0, 3) == 0);
            tick();
        end
        swap_req = 1'b0;
        run(2);
        chk1("bl_before_shutdown", bl_en, 1'b1);

        // Shutdown at (100,200); a pending swap is not served while shutting down
        pixel_x = 10'd100; pixel_y = 10'd200;
        enable  = 1'b0;
        tick();
        chk1("shutdown_bl_low", bl_en, 1'b0);
        chk1("shutdown_video_held", video_en, 1'b1);
        swap_req = 1'b1;
        run(10);
        fe_tick();
        chk1("shutdown_video", video_en, 1'b0);
        chk1("shutdown_timing", timing_rst_n, 1'b0);
        chk1("shutdown_panel", panel_rst_n, 1'b0);
        chk1("shutdown_no_ack", swap_ack, 1'b0);
        fe_tick();
        fe_tick();
        swap_req = 1'b0;
        run(3);

        // Abort on the 5th cycle of WAKE_WAIT, then a full restart
        enable  = 1'b1;
        en_edge = cyc + 1;
        run(R + 5);
        enable = 1'b0;
        tick();
        chk1("abort_panel_low", panel_rst_n, 1'b0);
        run(2);
        enable  = 1'b1;
        en_edge = cyc + 1;
        run(R + 2);
        chki("restart_pulse_len", panel_rise_cyc - en_edge, R);
        run(W + 2);
        chk1("restart_timing", timing_rst_n, 1'b1);

        // Reach RUN, make front_buf 1, then count up to 200 frames
        for (int f = 0; f < 3; f++) begin
            run(3);
            fe_tick();
        end
        if (m_front == 1'b0) begin
            swap_req = 1'b1;
            run(1);
            fe_tick();
            swap_req = 1'b0;
        end
        guard = 0;
        while (m_count != 8'd200 && guard < 400) begin
            run(1);
            fe_tick();
            guard++;
        end
        run(3);
        chk8("count_200", frame_count, 8'd200);
        chk1("front_1", front_buf, 1'b1);
        chk1("bl_on_before_rst", bl_en, 1'b1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk1("arst_panel", panel_rst_n, 1'b0);
        chk1("arst_timing", timing_rst_n, 1'b0);
        chk1("arst_video", video_en, 1'b0);
        chk1("arst_bl", bl_en, 1'b0);
        chk1("arst_front", front_buf, 1'b0);
        chk1("arst_ack", swap_ack, 1'b0);
        chk8("arst_count", frame_count, 8'd0);
        tick();
        rst_n = 1'b1;
        run(2);

        // Random lifecycles: enable toggles, frame ends and swap requests at random
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            rand_pix(6);
            swap_req = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_sequencer.md
# display_sequencer

Power-up/shutdown sequencer and frame-synchronous double-buffer scheduler for the 480x800@60 Hz panel path. It drives the panel reset, holds the video timing generator in reset until the panel has woken, and gates video and backlight on frame boundaries. It also arbitrates front/back framebuffer swaps requested by the spectrum renderer, applying each swap only at end of the active frame so that tearing cannot occur.

## Interface
- RESET_CYCLES, 300: cycles panel_rst_n is held low (10 µs at 30 MHz); range 1..2^24-1
- WAKE_CYCLES, 3600000: cycles from panel reset release to timing start (120 ms); range 1..2^24-1
- BL_DELAY_FRAMES, 2: frame ends between video_en and bl_en; range 1..255
- clk_pixel  in  1  pixel clock (~30 MHz)
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = panel on, 0 = orderly shutdown
- pixel_x  in  10  horizontal position from the timing generator
- pixel_y  in  10  vertical position from the timing generator
- swap_req  in  1  renderer holds high until swap_ack; back buffer complete
- panel_rst_n  out  1  panel hardware reset, active low
- timing_rst_n  out  1  reset for the timing generator, active low
- video_en  out  1  1 = pixel data passed, 0 = force black
- bl_en  out  1  backlight enable
- front_buf  out  1  index of the buffer being scanned out
- swap_ack  out  1  one-cycle pulse; swap performed
- frame_count  out  8  frames completed since timing start, wraps 255->0

## Operation
- frame_end = (pixel_x == 479 && pixel_y == 799), combinational, valid only while timing_rst_n = 1. A held-in-reset generator reports 0,0, so no false frame_end occurs.
- States: IDLE, RESET_ASSERT, WAKE_WAIT, FIRST_FRAME, BL_WAIT, RUN, SHUTDOWN. A 24-bit down-counter serves the delay states.
- IDLE: all outputs low except front_buf and frame_count, which hold. enable=1 -> RESET_ASSERT, load RESET_CYCLES.
- RESET_ASSERT: panel_rst_n=0. Lasts exactly RESET_CYCLES cycles -> WAKE_WAIT, load WAKE_CYCLES.
- WAKE_WAIT: panel_rst_n=1. Lasts exactly WAKE_CYCLES cycles -> FIRST_FRAME.
- FIRST_FRAME: timing_rst_n=1, video_en=0. On frame_end: video_en<=1, -> BL_WAIT, load BL_DELAY_FRAMES.
- BL_WAIT: decrement on each frame_end. At zero: bl_en<=1, -> RUN.
- RUN: steady state.
- enable=0 in RESET_ASSERT or WAKE_WAIT: -> IDLE immediately.
- enable=0 in FIRST_FRAME, BL_WAIT or RUN: bl_en<=0 next edge, -> SHUTDOWN.
- SHUTDOWN: on frame_end, video_en, timing_rst_n and panel_rst_n <= 0, -> IDLE. If enable returns to 1 while in SHUTDOWN, the state still completes to IDLE and then restarts.
- frame_count: +1 on every frame_end while timing_rst_n=1. Cleared on entry to FIRST_FRAME.
- Swap: in BL_WAIT or RUN, frame_end with swap_req=1 -> front_buf toggles and swap_ack=1 on the same edge.
  - A swap_req held across the next frame_end causes another swap. The renderer must drop swap_req after swap_ack.
  - In any other state swap_req stays pending and is never acknowledged there.
- rst_n low at any time: immediate return to reset values. front_buf and frame_count also clear.

## Timing
- Reset values: panel_rst_n=0, timing_rst_n=0, video_en=0, bl_en=0, front_buf=0, swap_ack=0, frame_count=0, state IDLE.
- All outputs are registered. Each reacts on the clock edge at which its condition is sampled, so it is visible 1 cycle after that condition.
- panel_rst_n low-pulse width = RESET_CYCLES. panel_rst_n rise to timing_rst_n rise = WAKE_CYCLES.
- video_en rises 1 cycle after the first frame_end, i.e. at pixel (480,799) timing, which is inside blanking.
- bl_en rises 1 cycle after the BL_DELAY_FRAMES-th subsequent frame_end.
- swap_ack is exactly 1 cycle wide, coincident with the front_buf change. Never more than one swap per frame.
- Shutdown: bl_en falls 1 cycle after enable falls. video_en, timing_rst_n and panel_rst_n fall together, 1 cycle after the next frame_end.

## Test plan
- Power-up with RESET_CYCLES=4, WAKE_CYCLES=10, BL_DELAY_FRAMES=2, enable=1 after reset:
  - panel_rst_n low 4 cycles.
  - timing_rst_n high 10 cycles later.
  - video_en high after frame 1; bl_en high after frame 3.
  - frame_count=3 at bl_en rise.
- Swap handshake: swap_req raised mid-frame in RUN -> front_buf toggles and swap_ack pulses 1 cycle at frame_end. Holding swap_req for 2 frames -> 2 toggles.
- Early swap: swap_req high during FIRST_FRAME -> no ack there. First ack at the frame_end that ends FIRST_FRAME+1 (in BL_WAIT).
- Shutdown: enable=0 at pixel (100,200) in RUN -> bl_en low next cycle. video_en, timing_rst_n and panel_rst_n low 1 cycle after (479,799). State IDLE.
- Abort in WAKE_WAIT: enable=0 at cycle 5 of WAKE_WAIT -> panel_rst_n low next cycle, IDLE. Re-enable -> full 4-cycle reset pulse repeats.
- rst_n asserted in RUN with front_buf=1 and frame_count=200 -> all outputs to reset values asynchronously, including front_buf=0 and frame_count=0.
